seg7_scan_ctrl: RTL

Parametrised multiplexed 7-segment display controller. It drives NUM_DIGITS common-anode digits and adds four features: a frame-coherent input snapshot, leading-zero blanking, per-digit blink and 8-level brightness PWM. It sits between the game score/status logic and the board's seg/an/dp pins.

---
 rtl/seg7_scan_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with per-frame input snapshot,
// leading-zero blanking, per-digit blink and 8-level brightness PWM.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 262144,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      lz_blank,
    input  logic [2:0]                brightness,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int SLICE = SCAN_DIV / 8;

    logic [DIV_W-1:0]                 div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [FRM_W-1:0]                 frame_cnt_q, frame_cnt_d;
    logic                             blink_phase_q, blink_phase_d;
    logic                             load_pend_q;

    logic [NUM_DIGITS-1:0][3:0]       sh_digits_q, sh_digits_d;
    logic [NUM_DIGITS-1:0]            sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]            sh_blank_q, sh_blank_d;
    logic [NUM_DIGITS-1:0]            sh_blink_q, sh_blink_d;
    logic                             sh_lz_q, sh_lz_d;
    logic [2:0]                       sh_bright_q, sh_bright_d;

    logic [NUM_DIGITS-1:0][3:0]       dig_v;
    logic [NUM_DIGITS-1:0]            dp_v, blank_v, blink_v;
    logic                             lz_v;
    logic [2:0]                       bright_v;

    logic                             end_slot, last_idx, end_frame, load;
    logic                             upper_nz, is_blank, lit;
    logic [3:0]                       cur;
    logic [DIV_W:0]                   thr;

    logic [6:0]                       seg_q, seg_d;
    logic [NUM_DIGITS-1:0]            an_q, an_d;
    logic                             dp_q, dp_d;
    logic                             frame_start_q, frame_start_d;

    function automatic logic [6:0] font7(input logic [3:0] v);
        case (v)
            4'h0:    font7 = 7'b1000000;
            4'h1:    font7 = 7'b1111001;
            4'h2:    font7 = 7'b0100100;
            4'h3:    font7 = 7'b0110000;
            4'h4:    font7 = 7'b0011001;
            4'h5:    font7 = 7'b0010010;
            4'h6:    font7 = 7'b0000010;
            4'h7:    font7 = 7'b1111000;
            4'h8:    font7 = 7'b0000000;
            4'h9:    font7 = 7'b0010000;
            4'hA:    font7 = 7'b0001000;
            4'hB:    font7 = 7'b0000011;
            4'hC:    font7 = 7'b1000110;
            4'hD:    font7 = 7'b0100001;
            4'hE:    font7 = 7'b0000110;
            default: font7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        end_slot  = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
        last_idx  = (idx_q == IDX_W'(NUM_DIGITS - 1));
        end_frame = end_slot && last_idx;
        load      = load_pend_q || end_frame;

        div_cnt_d = end_slot ? '0 : div_cnt_q + DIV_W'(1);
        idx_d     = idx_q;
        if (end_slot) begin
            idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
        end

        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (end_frame) begin
            if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRM_W'(1);
            end
        end

        sh_digits_d = load ? digits     : sh_digits_q;
        sh_dp_d     = load ? dp_in      : sh_dp_q;
        sh_blank_d  = load ? blank_mask : sh_blank_q;
        sh_blink_d  = load ? blink_mask : sh_blink_q;
        sh_lz_d     = load ? lz_blank   : sh_lz_q;
        sh_bright_d = load ? brightness : sh_bright_q;
    end

    // The first cycle after reset displays the inputs being captured right now,
    // so the opening frame is not shown from the cleared shadow registers.
    always_comb begin
        dig_v    = load_pend_q ? digits     : sh_digits_q;
        dp_v     = load_pend_q ? dp_in      : sh_dp_q;
        blank_v  = load_pend_q ? blank_mask : sh_blank_q;
        blink_v  = load_pend_q ? blink_mask : sh_blink_q;
        lz_v     = load_pend_q ? lz_blank   : sh_lz_q;
        bright_v = load_pend_q ? brightness : sh_bright_q;

        cur      = dig_v[idx_q];
        upper_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= idx_q) && (dig_v[i] != 4'd0)) begin
                upper_nz = 1'b1;
            end
        end

        is_blank = blank_v[idx_q]
                || (blink_v[idx_q] && blink_phase_q)
                || (cur == 4'hF)
                || (lz_v && (idx_q != '0) && !upper_nz);

        thr = (DIV_W+1)'((int'(bright_v) + 1) * SLICE);
        lit = ({1'b0, div_cnt_q} < thr);

        seg_d         = 7'h7F;
        an_d          = '1;
        dp_d          = 1'b1;
        frame_start_d = (idx_q == '0) && (div_cnt_q == '0);
        if (lit && !is_blank) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = font7(cur);
            dp_d  = ~dp_v[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            load_pend_q   <= 1'b1;
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '0;
            sh_blink_q    <= '0;
            sh_lz_q       <= 1'b0;
            sh_bright_q   <= '0;
            seg_q         <= 7'h7F;
            an_q          <= '1;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            load_pend_q   <= 1'b0;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            sh_blink_q    <= sh_blink_d;
            sh_lz_q       <= sh_lz_d;
            sh_bright_q   <= sh_bright_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule
